mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It holds the EXE/MEM pipeline register, captures the execute-stage results, and performs word loads and stores on a handshaked data-memory port. It stalls the upstream stages while an access is outstanding and presents write-back data, destination register and debug tags to the MEM/WB boundary.

## Interface
- `TIMEOUT`, default 16: maximum number of request cycles without `dmem_ack` before the access is abandoned.
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_wreg`, `ex_m2reg`, `ex_wmem`  in  1 each  execute-stage control: register write, load, store.
- `ex_aluR`  in  32  ALU result; the byte address for loads and stores.
- `ex_inB`  in  32  store data.
- `ex_destR`  in  5  destination register number.
- `EXE_ins_type`, `EXE_ins_number`  in  4 each  debug tags.
- `mem_stall`  out  1  freezes the upstream pipeline registers and the PC.
- `dmem_req`  out  1  data-memory request.
- `dmem_we`  out  1  1 for a store, 0 for a load.
- `dmem_addr`  out  32  word-aligned byte address.
- `dmem_wdata`  out  32  store data.
- `dmem_rdata`  in  32  load data; valid when `dmem_ack` is 1.
- `dmem_ack`  in  1  access-completion strobe.
- `mem_wreg`, `mem_m2reg`  out  1 each  write-back controls.
- `mem_aluR`, `mem_mdata`  out  32 each  ALU result and load data.
- `mem_destR`  out  5  destination register number.
- `MEM_ins_type`, `MEM_ins_number`  out  4 each  debug tags.
- `mem_err`  out  1  sticky error flag, set on a misaligned access or a timeout.

## Operation
- EXE/MEM register: captures all `ex_*`/`EXE_*` inputs on each rising edge where `mem_stall` = 0 and holds them otherwise. `mem_aluR`, `mem_destR`, `mem_m2reg` and the debug tags come directly from this register.
- Memory op: the held instruction has `m2reg` or `wmem` set. If both are set, it is treated as a store.
- Misalignment: a memory op with `aluR[1:0] != 0` issues no access. It sets `mem_err`, forces `mem_wreg` = 0, and causes no stall.
- FSM states:
  - IDLE: no access pending.
  - REQ: `dmem_req` = 1.
  - Transitions:
    - IDLE→REQ when an aligned memory op is captured.
    - REQ→IDLE on `dmem_ack`, unless a new aligned memory op is captured on the same edge, in which case the FSM stays in REQ.
    - REQ→IDLE on timeout.
- Bus outputs:
  - `dmem_addr` = `{aluR[31:2],2'b00}`, `dmem_we` = held `wmem`, `dmem_wdata` = held `inB`.
  - These are stable for the whole time `dmem_req` is high.
- `mem_stall` = (state == REQ) && !`dmem_ack` && !timeout_now. This is combinational.
- Load data: `mem_mdata` = `dmem_rdata` in the ack cycle. Outside the ack cycle, `mem_mdata` shows the last captured read data.
- `mem_wreg` = held `wreg` && !`mem_stall` && !misaligned && !timed_out. Squashing it makes the stalled and failed slots bubbles at MEM/WB.
- Timeout counter:
  - Cleared on entering REQ; increments each REQ cycle without ack.
  - timeout_now asserts when the counter reaches `TIMEOUT`-1 with no ack.
  - On timeout: the FSM goes to IDLE, `mem_err` is set, `mem_wreg` is 0 for that slot, and the stall releases.
- `mem_err` is cleared only by reset.

## Timing
- Reset (asynchronous, `rst_n` = 0): all register fields 0, FSM IDLE, counter 0, `mem_err` 0. All outputs 0, including `dmem_req` and `mem_stall`. Reset mid-access abandons the access immediately, with no completion.
- Non-memory instruction: one cycle in the stage, no stall.
- Memory op with ack in the first REQ cycle: one cycle, no stall.
- Memory op with ack after N extra cycles: `mem_stall` is high for exactly N cycles.
- Back-to-back memory ops: `dmem_req` stays high continuously. The address and controls change on the ack edge.
- `dmem_ack` while in IDLE is ignored.
- Timeout: the slot leaves the stage after exactly `TIMEOUT` REQ cycles.

## Structure
- Shared pipeline package:
  - `TIMEOUT` default.
  - Debug tag width (4).
  - FSM state encoding: IDLE=1'b0, REQ=1'b1.
- Natural sub-module: `Reg_EXE_MEM`, the EXE/MEM pipeline register with hold-enable and asynchronous reset.
- The FSM, counter and muxing stay in `mem_stage`.

## Test plan
- Reset during REQ:
  - Stimulus: load of 0x40, assert `rst_n` = 0 in the 2nd stall cycle.
  - Response: `dmem_req`, `mem_stall`, `mem_wreg`, `mem_err` all 0 immediately; FSM IDLE after release.
- ALU op:
  - Stimulus: `ex_wreg`=1, `ex_aluR`=0x1234, `ex_destR`=5.
  - Response: next cycle `mem_wreg`=1, `mem_aluR`=0x1234, `mem_destR`=5, `dmem_req`=0, `mem_stall`=0.
- Zero-wait load:
  - Stimulus: address 0x100; responder acks in the first cycle with 0xDEADBEEF.
  - Response: `mem_mdata`=0xDEADBEEF, `mem_wreg`=1, no stall.
- 3-wait store:
  - Stimulus: address 0x200, data 0xA5A5A5A5; ack on the 4th REQ cycle.
  - Response: `mem_stall` high 3 cycles; `dmem_addr` and `dmem_wdata` stable throughout; `dmem_we`=1.
- Back-to-back loads:
  - Stimulus: loads from 0x10, 0x14, 0x18, each with 1-cycle-late ack.
  - Response: `dmem_req` continuously high; addresses advance on the ack edges; 3 writes at MEM/WB in order.
- Faults:
  - Stimulus: a load from 0x102, then a load from 0x300 that is never acked.
  - Response: first load gives no request and `mem_err`=1; second load is abandoned after 16 cycles with `mem_wreg`=0, `mem_err` still 1, and the stall released.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage_pkg : shared types/constants for the MIPS MEM stage      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mem_stage_pkg;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int TAG_W           = 4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic             wreg;
    logic             m2reg;
    logic             wmem;
    logic [31:0]      alu_r;
    logic [31:0]      in_b;
    logic [4:0]       dest_r;
    logic [TAG_W-1:0] ins_type;
    logic [TAG_W-1:0] ins_number;
  } exe_mem_t;

  function automatic logic is_mem_op(input exe_mem_t e);
    return e.m2reg | e.wmem;
  endfunction

  function automatic logic is_aligned_mem_op(input exe_mem_t e);
    return (e.m2reg | e.wmem) && (e.alu_r[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Reg_EXE_MEM : EXE/MEM pipeline register, hold-enable, async reset  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module Reg_EXE_MEM
  import mem_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  exe_mem_t d,
  output exe_mem_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage : MIPS memory-access stage with handshaked data port     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic             ex_wmem,
  input  logic [31:0]      ex_aluR,
  input  logic [31:0]      ex_inB,
  input  logic [4:0]       ex_destR,
  input  logic [TAG_W-1:0] EXE_ins_type,
  input  logic [TAG_W-1:0] EXE_ins_number,
  output logic             mem_stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_ack,
  output logic             mem_wreg,
  output logic             mem_m2reg,
  output logic [31:0]      mem_aluR,
  output logic [31:0]      mem_mdata,
  output logic [4:0]       mem_destR,
  output logic [TAG_W-1:0] MEM_ins_type,
  output logic [TAG_W-1:0] MEM_ins_number,
  output logic             mem_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  exe_mem_t           ex_d;
  exe_mem_t           held;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic               in_req;
  logic               timeout_now;
  logic               misaligned;
  logic               capture;

  assign ex_d = '{wreg: ex_wreg, m2reg: ex_m2reg, wmem: ex_wmem,
                  alu_r: ex_aluR, in_b: ex_inB, dest_r: ex_destR,
                  ins_type: EXE_ins_type, ins_number: EXE_ins_number};

  Reg_EXE_MEM u_reg_exe_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (capture),
    .d     (ex_d),
    .q     (held)
  );

  assign in_req      = (state == REQ);
  assign timeout_now = in_req && !dmem_ack && (cnt == CNT_W'(TIMEOUT - 1));
  assign mem_stall   = in_req && !dmem_ack && !timeout_now;
  assign capture     = !mem_stall;
  assign misaligned  = is_mem_op(held) && (held.alu_r[1:0] != 2'b00);

  // A stalled cycle is always a REQ cycle without ack, so the counter
  // only advances while stalled and restarts with every new slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (capture) begin
        state <= is_aligned_mem_op(ex_d) ? REQ : IDLE;
        cnt   <= '0;
      end else begin
        cnt   <= cnt + 1'b1;
      end
      if (in_req && dmem_ack) rdata_q <= dmem_rdata;
      if (misaligned || timeout_now) err_q <= 1'b1;
    end
  end

  assign dmem_req       = in_req;
  assign dmem_we        = held.wmem;
  assign dmem_addr      = {held.alu_r[31:2], 2'b00};
  assign dmem_wdata     = held.in_b;

  assign mem_wreg       = held.wreg && !mem_stall && !misaligned && !timeout_now;
  assign mem_m2reg      = held.m2reg;
  assign mem_aluR       = held.alu_r;
  assign mem_mdata      = (in_req && dmem_ack) ? dmem_rdata : rdata_q;
  assign mem_destR      = held.dest_r;
  assign MEM_ins_type   = held.ins_type;
  assign MEM_ins_number = held.ins_number;
  assign mem_err        = err_q || misaligned || timeout_now;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_stage : directed self-checking bench for mem_stage          |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_wreg, ex_m2reg, ex_wmem;
  logic [31:0] ex_aluR, ex_inB;
  logic [4:0]  ex_destR;
  logic [3:0]  EXE_ins_type, EXE_ins_number;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        mem_wreg, mem_m2reg;
  logic [31:0] mem_aluR, mem_mdata;
  logic [4:0]  mem_destR;
  logic [3:0]  MEM_ins_type, MEM_ins_number;
  logic        mem_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
    .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .mem_aluR(mem_aluR), .mem_mdata(mem_mdata), .mem_destR(mem_destR),
    .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number),
    .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic set_ex(input logic w, input logic ld, input logic st,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dst);
    ex_wreg = w; ex_m2reg = ld; ex_wmem = st;
    ex_aluR = a; ex_inB = b; ex_destR = dst;
    EXE_ins_type = 4'h3; EXE_ins_number = {dst[3:0]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int stalls;

  initial begin
    set_ex(0, 0, 0, 0, 0, 0);
    dmem_ack = 0; dmem_rdata = 0;
    #12;
    check("rst_req",   32'(dmem_req), 0);
    check("rst_stall", 32'(mem_stall), 0);
    check("rst_err",   32'(mem_err), 0);
    check("rst_alu",   mem_aluR, 0);
    check("rst_mdata", mem_mdata, 0);
    @(negedge clk); rst_n = 1;

    // ALU op
    set_ex(1, 0, 0, 32'h1234, 0, 5);
    step();
    check("alu_wreg",  32'(mem_wreg), 1);
    check("alu_aluR",  mem_aluR, 32'h1234);
    check("alu_dest",  32'(mem_destR), 5);
    check("alu_req",   32'(dmem_req), 0);
    check("alu_stall", 32'(mem_stall), 0);
    check("alu_tag",   32'(MEM_ins_number), 5);

    // Zero-wait load
    set_ex(1, 1, 0, 32'h100, 0, 7);
    step();
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    set_ex(0, 0, 0, 0, 0, 0);
    #1;
    check("zw_req",   32'(dmem_req), 1);
    check("zw_addr",  dmem_addr, 32'h100);
    check("zw_we",    32'(dmem_we), 0);
    check("zw_stall", 32'(mem_stall), 0);
    check("zw_mdata", mem_mdata, 32'hDEADBEEF);
    check("zw_wreg",  32'(mem_wreg), 1);
    step();
    dmem_ack = 0; dmem_rdata = 32'h0; #1;
    check("zw_idle",  32'(dmem_req), 0);
    check("zw_hold",  mem_mdata, 32'hDEADBEEF);

    // 3-wait store; upstream changes during the stall must not leak in
    set_ex(0, 0, 1, 32'h200, 32'hA5A5A5A5, 0);
    step();
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_stall) stalls++;
      check("st_addr",  dmem_addr, 32'h200);
      check("st_wdata", dmem_wdata, 32'hA5A5A5A5);
      check("st_we",    32'(dmem_we), 1);
      set_ex(1, 1, 0, 32'h999, 32'h1, 3);
      step();
    end
    set_ex(0, 0, 0, 0, 0, 0);
    dmem_ack = 1; #1;
    check("st_nstall", 32'(stalls), 3);
    check("st_ackstl", 32'(mem_stall), 0);
    check("st_addr4",  dmem_addr, 32'h200);
    check("st_wdata4", dmem_wdata, 32'hA5A5A5A5);
    check("st_wreg",   32'(mem_wreg), 0);
    step();
    dmem_ack = 0; #1;
    check("st_idle", 32'(dmem_req), 0);

    // Back-to-back loads, ack on the second REQ cycle of each
    set_ex(1, 1, 0, 32'h10, 0, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      dmem_ack = 0; #1;
      check("b2b_req_a",   32'(dmem_req), 1);
      check("b2b_addr_a",  dmem_addr, 32'h10 + 32'(4 * i));
      check("b2b_stall_a", 32'(mem_stall), 1);
      check("b2b_wreg_a",  32'(mem_wreg), 0);
      if (i < 2) set_ex(1, 1, 0, 32'h14 + 32'(4 * i), 0, 5'(i + 2));
      else       set_ex(0, 0, 0, 0, 0, 0);
      step();
      dmem_ack = 1; dmem_rdata = 32'h1000 + 32'(i); #1;
      check("b2b_req_b",   32'(dmem_req), 1);
      check("b2b_addr_b",  dmem_addr, 32'h10 + 32'(4 * i));
      check("b2b_stall_b", 32'(mem_stall), 0);
      check("b2b_wreg_b",  32'(mem_wreg), 1);
      check("b2b_dest",    32'(mem_destR), 32'(i + 1));
      check("b2b_mdata",   mem_mdata, 32'h1000 + 32'(i));
      step();
    end
    dmem_ack = 0; #1;
    check("b2b_idle", 32'(dmem_req), 0);

    // Misaligned load
    set_ex(1, 1, 0, 32'h102, 0, 9);
    step();
    check("mis_req",   32'(dmem_req), 0);
    check("mis_stall", 32'(mem_stall), 0);
    check("mis_wreg",  32'(mem_wreg), 0);
    check("mis_err",   32'(mem_err), 1);

    // Load that is never acked
    set_ex(1, 1, 0, 32'h300, 0, 10);
    step();
    set_ex(0, 0, 0, 0, 0, 0);
    stalls = 0;
    while (mem_stall && stalls < 40) begin
      stalls++;
      step();
    end
    check("to_nstall", 32'(stalls), 15);
    check("to_req",    32'(dmem_req), 1);
    check("to_wreg",   32'(mem_wreg), 0);
    check("to_err",    32'(mem_err), 1);
    step();
    check("to_idle",   32'(dmem_req), 0);
    check("to_err2",   32'(mem_err), 1);

    // Reset in the 2nd stall cycle of a load
    set_ex(1, 1, 0, 32'h40, 0, 4);
    step();
    set_ex(0, 0, 0, 0, 0, 0);
    step();
    check("rr_stall_pre", 32'(mem_stall), 1);
    rst_n = 0; #1;
    check("rr_req",   32'(dmem_req), 0);
    check("rr_stall", 32'(mem_stall), 0);
    check("rr_wreg",  32'(mem_wreg), 0);
    check("rr_err",   32'(mem_err), 0);
    @(negedge clk); rst_n = 1;
    step();
    check("rr_idle",  32'(dmem_req), 0);
    check("rr_stl2",  32'(mem_stall), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
